pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Owns the architectural PC register and sequences each instruction fetch from imem over a valid/ready request channel.
//  Presents {instr, pc, pc_plus4} to decode and holds them until the core retires the instruction (instr_ready).
//  On retire, loads pc_next, which is the mux output selecting PCTarget/PCPlus4, and starts the next fetch.
//  Sits directly downstream of the PC-select mux and upstream of decode/regfile.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  RSP_TIMEOUT   16             max cycles in WAIT before fetch_err; valid range 2..255
//  TRAP_VECTOR   32'h0000_0100  redirect target on misaligned pc_next (only with PC_MISALIGN_TRAP_EN)
// PORTS
//  clk             in   1   single clock, rising edge
//  reset           in   1   synchronous, active-high
//  pc_next         in   32  next PC from PC-select mux; sampled only on retire
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   imem accepts request
//  imem_addr       out  32  fetch address (= pc)
//  imem_rsp_valid  in   1   read data valid (1 pulse per accepted request)
//  imem_rsp_data   in   32  instruction word
//  instr_valid     out  1   instr/pc/pc_plus4 are valid for decode
//  instr_ready     in   1   core retires current instruction this cycle
//  instr           out  32  held instruction word
//  pc              out  32  current PC
//  pc_plus4        out  32  pc + 4, mod 2^32
//  fetch_err       out  1   sticky; response timeout (or misalign trap, see CONFIGURATION)
// BEHAVIOUR
//  Reset (any state, any cycle): state=REQ, pc=RESET_VECTOR, instr=32'h0000_0013 (NOP), instr_valid=0,
//   imem_req_valid=0 in the reset cycle, fetch_err=0, timeout counter=0. imem is reset by the same reset;
//   in-flight responses are discarded.
//  FSM states: REQ, WAIT, HOLD.
//   REQ : imem_req_valid=1, imem_addr=pc. If imem_req_ready -> WAIT, cnt=0. Valid stays high and addr stable until ready.
//   WAIT: if imem_rsp_valid -> instr<=imem_rsp_data, HOLD. Otherwise cnt++.
//         When cnt==RSP_TIMEOUT-1 with no rsp -> fetch_err<=1, instr<=NOP, HOLD (NOP retires normally).
//   HOLD: instr_valid=1. If instr_ready -> pc<=pc_next, instr_valid<=0, REQ.
//  Latency: 0-wait imem: request accepted in cycle 0, response in cycle 1, instr_valid in cycle 2.
//   Min 3 cycles per instruction.
//  instr_valid is registered; deasserts the cycle after retire.
//  instr_ready while instr_valid=0 is ignored.
//  imem_rsp_valid outside WAIT is ignored; no state change.
//  imem_rsp_valid arriving in the same cycle as a timeout: the response wins, and fetch_err is not set.
//  pc_plus4 is combinational from pc. 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
//  pc_next is used as-is; bits[1:0] pass unchanged when the macro is off.
//  fetch_err clears only on reset.
// CONFIGURATION
//  `define PC_MISALIGN_TRAP_EN:
//   on retire, if pc_next[1:0]!=0 -> pc<=TRAP_VECTOR and fetch_err<=1.
//  Without it: no check; pc<=pc_next exactly; the TRAP_VECTOR parameter is unused.
// STRUCTURE
//  Shared package/header rv_core_pkg: FSM state localparams (REQ=2'd0, WAIT=2'd1, HOLD=2'd2), NOP_INSTR=32'h0000_0013,
//   default RESET_VECTOR.
//  Sub-module pc_register: 32-bit register with sync reset to RESET_VECTOR and load enable.
//   Instantiated once; the FSM, timeout counter and instr latch live in the top.
// TESTING
//  1 Reset, imem 0-wait, instr_ready=1, pc_next=pc_plus4
//    -> imem_addr 0,4,8 accepted every 3 cycles; first instr_valid 2 cycles after first req accept.
//  2 imem_req_ready held low 5 cycles
//    -> imem_req_valid high 5 cycles, imem_addr stable at pc; no instr_valid.
//  3 In HOLD, pc_next=32'h0000_0040, instr_ready pulsed 1 cycle
//    -> next imem_addr=0x40; instr_ready held low keeps instr/pc stable.
//  4 No rsp for 16 cycles in WAIT
//    -> fetch_err=1, instr=0x00000013, instr_valid=1.
//    Variant: rsp on cycle 15 -> data captured, fetch_err stays 0.
//  5 Reset asserted in WAIT and HOLD
//    -> next cycle pc=RESET_VECTOR, instr_valid=0; a late rsp is ignored.
//  6 pc=0xFFFFFFFC -> pc_plus4=0.
//    With PC_MISALIGN_TRAP_EN, pc_next=0x102 on retire -> pc=0x100, fetch_err=1.
//    Without it -> pc=0x102.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared fetch-controller types and constants: FSM state encoding, NOP word, default vectors.
package rv_core_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned DEFAULT_RSP_TIMEOUT  = 16;

  // Sequential PC successor; wraps silently at 2^32.
  function automatic logic [31:0] pc_inc4(input logic [31:0] p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Architectural PC flop: synchronous reset to RESET_VECTOR, loads d when load_en is high.
module pc_register
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) pc_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

  assign q = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and imem fetch sequencer (REQ -> WAIT -> HOLD), holding the fetched word for decode.
// Optional misaligned-target trap on retire is enabled with `define PC_MISALIGN_TRAP_EN.
//
// state | meaning
// REQ   | request to imem at pc; waits for imem_req_ready
// WAIT  | waiting for the response, timeout counter running
// HOLD  | instr/pc/pc_plus4 valid for decode until retire
module pc_fetch_ctrl
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned RSP_TIMEOUT  = DEFAULT_RSP_TIMEOUT,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam logic [7:0] CNT_LAST = 8'(RSP_TIMEOUT - 1);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

  fetch_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         req_valid_q, req_valid_d;
  logic         fetch_err_q, fetch_err_d;

  logic         pc_load;
  logic [31:0]  pc_load_val;
  logic [31:0]  pc_cur;

  pc_register #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_register (
    .clk    (clk),
    .reset  (reset),
    .load_en(pc_load),
    .d      (pc_load_val),
    .q      (pc_cur)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    fetch_err_d = fetch_err_q;
    pc_load     = 1'b0;
    pc_load_val = pc_next;

    unique case (state_q)
      REQ: begin
        // The request register is cleared by reset, so the first request goes out one cycle later.
        if (req_valid_q && imem_req_ready) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          fetch_err_d = 1'b1;
          instr_d     = NOP_INSTR;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_load = 1'b1;
          state_d = REQ;
          if (TRAP_EN && (pc_next[1:0] != 2'b00)) begin
            pc_load_val = TRAP_VECTOR;
            fetch_err_d = 1'b1;
          end
        end
      end
      default: state_d = REQ;
    endcase

    instr_valid_d = (state_d == HOLD);
    req_valid_d   = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= REQ;
      cnt_q         <= 8'd0;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      req_valid_q   <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      req_valid_q   <= req_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_cur;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign pc             = pc_cur;
  assign pc_plus4       = pc_inc4(pc_cur);
  assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: transaction-level fetch model checked every cycle plus directed literal checks.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] TV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  logic        auto_mem, man_ready, man_rsp, follow;
  logic [31:0] man_data, man_pc_next;
  logic        acc_q;
  logic [31:0] acc_addr_q;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .pc_next       (pc_next),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_err     (fetch_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h5A5A} ^ {16'h0000, a[31:16]};
  endfunction

  // zero-wait imem: answers the cycle after each accepted request
  always @(posedge clk) begin
    if (reset) acc_q <= 1'b0;
    else       acc_q <= imem_req_valid && imem_req_ready;
    acc_addr_q <= imem_addr;
  end

  assign imem_req_ready = auto_mem ? 1'b1 : man_ready;
  assign imem_rsp_valid = auto_mem ? acc_q : man_rsp;
  assign imem_rsp_data  = auto_mem ? mem_word(acc_addr_q) : man_data;
  assign pc_next        = follow ? pc_plus4 : man_pc_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: what the fetch unit owes decode and imem, in transaction terms.
  typedef struct {
    logic        init;
    logic        requesting;
    logic        outstanding;
    logic        presenting;
    logic        err;
    logic [31:0] arch_pc;
    logic [31:0] word;
    int          silent;
  } model_t;

  model_t m = '{init: 1'b0, requesting: 1'b0, outstanding: 1'b0, presenting: 1'b0,
                err: 1'b0, arch_pc: 32'h0, word: 32'h0, silent: 0};

  function automatic model_t model_step(input model_t s, input logic rst, input logic rdy,
                                        input logic rv, input logic [31:0] rd,
                                        input logic ir, input logic [31:0] pn);
    model_t n = s;
    if (rst) begin
      n.init = 1'b1; n.requesting = 1'b0; n.outstanding = 1'b0; n.presenting = 1'b0;
      n.err = 1'b0; n.arch_pc = RV; n.word = NOP; n.silent = 0;
    end else if (!s.init) begin
      n = s;
    end else if (s.requesting) begin
      if (rdy) begin n.requesting = 1'b0; n.outstanding = 1'b1; n.silent = 0; end
    end else if (s.outstanding) begin
      if (rv) begin
        n.word = rd; n.outstanding = 1'b0; n.presenting = 1'b1;
      end else if (s.silent + 1 == TMO) begin
        n.err = 1'b1; n.word = NOP; n.outstanding = 1'b0; n.presenting = 1'b1;
      end else begin
        n.silent = s.silent + 1;
      end
    end else if (s.presenting) begin
      if (ir) begin
        n.presenting = 1'b0; n.requesting = 1'b1; n.arch_pc = pn;
`ifdef PC_MISALIGN_TRAP_EN
        if (pn[1:0] != 2'b00) begin n.arch_pc = TV; n.err = 1'b1; end
`endif
      end
    end else begin
      n.requesting = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= model_step(m, reset, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_next);

  always @(negedge clk) begin
    if (m.init) begin
      chk("req_valid", 32'(imem_req_valid), 32'(m.requesting));
      if (m.requesting) chk("imem_addr", imem_addr, m.arch_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m.presenting));
      chk("instr", instr, m.word);
      chk("pc", pc, m.arch_pc);
      chk("pc_plus4", pc_plus4, m.arch_pc + 32'd4);
      chk("fetch_err", 32'(fetch_err), 32'(m.err));
    end
  end

  // Accept / instr_valid-rise log for latency checks
  int          cyc = 0;
  logic        iv_prev = 1'b0;
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  int          iv_cyc[$];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    iv_prev <= instr_valid;
    if (!reset && imem_req_valid && imem_req_ready) begin
      acc_log.push_back(imem_addr);
      acc_cyc.push_back(cyc);
    end
    if (!reset && instr_valid && !iv_prev) iv_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_iv(input string name);
    for (int k = 0; k < 40 && instr_valid !== 1'b1; k++) tick();
    chk(name, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1; auto_mem = 1'b1; man_ready = 1'b0; man_rsp = 1'b0; man_data = 32'h0;
    follow = 1'b1; man_pc_next = 32'h0; instr_ready = 1'b1;
    tick(); tick();
    chk("rst_pc", pc, RV);
    chk("rst_instr", instr, NOP);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    reset = 1'b0;

    // 1: zero-wait streaming
    repeat (10) tick();
    chk("s1_n_accepts", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) begin
      chk("s1_addr0", acc_log[0], 32'h0);
      chk("s1_addr1", acc_log[1], 32'h4);
      chk("s1_addr2", acc_log[2], 32'h8);
      chk("s1_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      chk("s1_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
    chk("s1_n_iv", 32'(iv_cyc.size() >= 1), 32'd1);
    if (iv_cyc.size() >= 1 && acc_cyc.size() >= 1)
      chk("s1_latency", 32'(iv_cyc[0] - acc_cyc[0]), 32'd2);

    // 2: imem stalls request for 5 cycles
    instr_ready = 1'b0;
    wait_iv("s2_park");
    auto_mem = 1'b0; man_ready = 1'b0; man_rsp = 1'b0;
    follow = 1'b0; man_pc_next = 32'h0000_0020;
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("s2_req_valid", 32'(imem_req_valid), 32'd1);
      chk("s2_addr", imem_addr, 32'h0000_0020);
      chk("s2_iv", 32'(instr_valid), 32'd0);
      tick();
    end
    man_ready = 1'b1; tick(); man_ready = 1'b0;

    // 4 variant: response on the last allowed WAIT cycle wins over the timeout
    repeat (15) tick();
    man_rsp = 1'b1; man_data = 32'hDEAD_BEEF; tick(); man_rsp = 1'b0;
    chk("s4v_iv", 32'(instr_valid), 32'd1);
    chk("s4v_instr", instr, 32'hDEAD_BEEF);
    chk("s4v_err", 32'(fetch_err), 32'd0);

    // 3: hold while not retired, then redirect to 0x40
    man_pc_next = 32'h0000_0040;
    repeat (3) tick();
    chk("s3_hold_instr", instr, 32'hDEAD_BEEF);
    chk("s3_hold_pc", pc, 32'h0000_0020);
    chk("s3_hold_iv", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    chk("s3_addr", imem_addr, 32'h0000_0040);
    chk("s3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("s3_iv_drop", 32'(instr_valid), 32'd0);

    // 4: response timeout
    man_ready = 1'b1; tick(); man_ready = 1'b0;
    repeat (15) tick();
    chk("s4_err_early", 32'(fetch_err), 32'd0);
    chk("s4_iv_early", 32'(instr_valid), 32'd0);
    tick();
    chk("s4_err", 32'(fetch_err), 32'd1);
    chk("s4_instr", instr, NOP);
    chk("s4_iv", 32'(instr_valid), 32'd1);

    // 5: reset in HOLD, then reset in WAIT followed by a late response
    reset = 1'b1; tick(); reset = 1'b0;
    chk("s5h_pc", pc, RV);
    chk("s5h_iv", 32'(instr_valid), 32'd0);
    chk("s5h_err", 32'(fetch_err), 32'd0);
    tick();
    man_ready = 1'b1; tick(); man_ready = 1'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    man_rsp = 1'b1; man_data = 32'hBAD0_0BAD; tick(); man_rsp = 1'b0;
    chk("s5w_iv", 32'(instr_valid), 32'd0);
    chk("s5w_instr", instr, NOP);
    chk("s5w_req_valid", 32'(imem_req_valid), 32'd1);
    chk("s5w_pc", pc, RV);

    // 6: wrap of pc_plus4 and misaligned pc_next
    man_pc_next = 32'hFFFF_FFFC; instr_ready = 1'b1; auto_mem = 1'b1;
    for (int k = 0; k < 20 && pc !== 32'hFFFF_FFFC; k++) tick();
    chk("s6_reach", pc, 32'hFFFF_FFFC);
    chk("s6_wrap", pc_plus4, 32'h0000_0000);
    man_pc_next = 32'h0000_0102;
    for (int k = 0; k < 20 && pc === 32'hFFFF_FFFC; k++) tick();
`ifdef PC_MISALIGN_TRAP_EN
    chk("s6_trap_pc", pc, TV);
    chk("s6_trap_err", 32'(fetch_err), 32'd1);
`else
    chk("s6_pc", pc, 32'h0000_0102);
    chk("s6_err", 32'(fetch_err), 32'd0);
`endif
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
